// File: rtl/mem_pkg.sv
// Shared definitions for the parametrised memory system: FSM states and op encoding.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        CLEAR  = 2'd3
    } state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/ram_p.sv
// Synchronous single-port word array with a write enable and a registered read.
// Contents are deliberately not reset.
module ram_p #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_system_p.sv
// Request/clear sequencer in front of ram_p: latches one request at a time,
// flags out-of-range addresses, and zeroes the whole array on a clear.
//
// state  | meaning
// IDLE   | not busy; accepts clr (priority) or select
// ACCESS | latched request executes: write, registered read, or o_err
// DONE   | registered read word presented with o_valid
// CLEAR  | one word zeroed per cycle, counter 0 .. DEPTH-1
module mem_system_p
    import mem_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int TRISTATE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i,
    input  logic [ADDR_W-1:0] adr,
    input  logic              op,
    input  logic              select,
    input  logic              clr,
    output logic [DATA_W-1:0] o,
    output logic              o_valid,
    output logic              o_err,
    output logic              busy
);

    localparam int               RAM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH itself is representable when it is a power of two.
    localparam logic [ADDR_W:0]  ADR_LIMIT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

    state_t             r_state;
    state_t             w_next;
    logic [ADDR_W-1:0]  r_adr;
    logic [ADDR_W-1:0]  r_clr_cnt;
    logic               r_op;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  w_rdata;
    logic [DATA_W-1:0]  w_ram_wdata;
    logic [RAM_AW-1:0]  w_ram_addr;
    logic               w_in_range;
    logic               w_clr_last;
    logic               w_we;
    logic               w_re;

    assign w_in_range = {1'b0, r_adr} < ADR_LIMIT;
    assign w_clr_last = (r_clr_cnt == CLR_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_next;
            r_clr_cnt <= (r_state == CLEAR && !w_clr_last) ? r_clr_cnt + ADDR_W'(1) : '0;
        end
    end

    // Request copies are pure datapath; only read once the FSM has left IDLE.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && select && !clr) begin
            r_adr   <= adr;
            r_op    <= op;
            r_wdata <= i;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_we        = 1'b0;
        w_re        = 1'b0;
        busy        = 1'b1;
        o_valid     = 1'b0;
        o_err       = 1'b0;
        w_ram_addr  = r_adr[RAM_AW-1:0];
        w_ram_wdata = r_wdata;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (clr) begin
                    w_next = CLEAR;
                end else if (select) begin
                    w_next = ACCESS;
                end
            end
            ACCESS: begin
                if (!w_in_range) begin
                    o_err  = 1'b1;
                    w_next = IDLE;
                end else if (r_op == OP_WRITE) begin
                    w_we   = 1'b1;
                    w_next = IDLE;
                end else begin
                    w_re   = 1'b1;
                    w_next = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                w_next  = IDLE;
            end
            CLEAR: begin
                w_we        = 1'b1;
                w_ram_addr  = r_clr_cnt[RAM_AW-1:0];
                w_ram_wdata = '0;
                if (w_clr_last) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        // Reset wins over an in-flight write or clear step and quiets the strobes.
        if (rst) begin
            w_we    = 1'b0;
            busy    = 1'b0;
            o_valid = 1'b0;
            o_err   = 1'b0;
        end
    end

    ram_p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_rdata)
    );

    generate
        if (TRISTATE != 0) begin : g_tri
            assign o = o_valid ? w_rdata : {DATA_W{1'bz}};
        end else begin : g_zero
            assign o = o_valid ? w_rdata : '0;
        end
    endgenerate

endmodule

// File: tb/tb_mem_system_p.sv
// Directed plus randomized bench for mem_system_p: a default 8x8 tri-state
// instance (A) and a 16-bit, 6-deep, zero-idle instance (B) against array models.
module tb_mem_system_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic [7:0]  i_a;
    logic [2:0]  adr_a;
    logic        op_a, sel_a, clr_a;
    wire  [7:0]  o_a;
    logic        vld_a, err_a, bsy_a;

    logic [15:0] i_b;
    logic [2:0]  adr_b;
    logic        op_b, sel_b, clr_b;
    wire  [15:0] o_b;
    logic        vld_b, err_b, bsy_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  mdl_a [8];
    logic [15:0] mdl_b [6];

    mem_system_p #(.DATA_W(8), .DEPTH(8), .TRISTATE(1)) dut_a (
        .clk(clk), .rst(rst), .i(i_a), .adr(adr_a), .op(op_a), .select(sel_a),
        .clr(clr_a), .o(o_a), .o_valid(vld_a), .o_err(err_a), .busy(bsy_a)
    );

    mem_system_p #(.DATA_W(16), .DEPTH(6), .TRISTATE(0)) dut_b (
        .clk(clk), .rst(rst), .i(i_b), .adr(adr_b), .op(op_b), .select(sel_b),
        .clr(clr_b), .o(o_b), .o_valid(vld_b), .o_err(err_b), .busy(bsy_b)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] o_of(input bit b);
        return b ? o_b : {8'h00, o_a};
    endfunction

    function automatic logic [15:0] idle_o(input bit b);
        logic [7:0] zz;
        zz = 8'hzz;
        return b ? 16'h0000 : {8'h00, zz};
    endfunction

    function automatic logic [15:0] bsy(input bit b);
        return {15'd0, b ? bsy_b : bsy_a};
    endfunction

    function automatic logic [15:0] vld(input bit b);
        return {15'd0, b ? vld_b : vld_a};
    endfunction

    function automatic logic [15:0] err(input bit b);
        return {15'd0, b ? err_b : err_a};
    endfunction

    task automatic drive(input bit b, input bit s, input bit o, input logic [2:0] a,
                         input logic [15:0] d, input bit c);
        if (b) begin
            sel_b = s; op_b = o; adr_b = a; i_b = d; clr_b = c;
        end else begin
            sel_a = s; op_a = o; adr_a = a; i_a = d[7:0]; clr_a = c;
        end
    endtask

    task automatic wr(input bit b, input logic [2:0] a, input logic [15:0] d);
        drive(b, 1'b1, 1'b1, a, d, 1'b0);
        tick();
        check("wr_busy", bsy(b), 16'd1);
        check("wr_err", err(b), 16'd0);
        drive(b, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
        tick();
        check("wr_free", bsy(b), 16'd0);
        if (b) mdl_b[a] = d;
        else   mdl_a[a] = d[7:0];
    endtask

    // Optional spam: keep a write to adr 5 pending while the read is busy.
    task automatic rd(input bit b, input logic [2:0] a, input bit spam);
        logic [15:0] exp;
        exp = b ? mdl_b[a] : {8'h00, mdl_a[a]};
        check("rd_pre_busy", bsy(b), 16'd0);
        drive(b, 1'b1, 1'b0, a, 16'h0, 1'b0);
        tick();
        check("rd_busy1", bsy(b), 16'd1);
        check("rd_novalid1", vld(b), 16'd0);
        check("rd_idle_o1", o_of(b), idle_o(b));
        if (spam) drive(b, 1'b1, 1'b1, 3'd5, 16'($urandom), 1'b0);
        else      drive(b, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
        tick();
        check("rd_busy2", bsy(b), 16'd1);
        check("rd_valid", vld(b), 16'd1);
        check("rd_data", o_of(b), exp);
        tick();
        drive(b, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
        check("rd_busy3", bsy(b), 16'd0);
        check("rd_novalid3", vld(b), 16'd0);
        check("rd_idle_o3", o_of(b), idle_o(b));
    endtask

    // Clear with a simultaneous select that must be dropped.
    task automatic clear_all(input bit b, input int depth);
        drive(b, 1'b1, 1'b1, 3'd2, 16'h0011, 1'b1);
        tick();
        drive(b, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
        for (int k = 0; k < depth; k++) begin
            check("clr_busy", bsy(b), 16'd1);
            tick();
        end
        check("clr_end", bsy(b), 16'd0);
        for (int k = 0; k < depth; k++) begin
            if (b) mdl_b[k] = 16'h0;
            else   mdl_a[k] = 8'h00;
        end
    endtask

    task automatic oor(input bit o, input logic [2:0] a, input logic [15:0] d);
        drive(1'b1, 1'b1, o, a, d, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
        check("oor_err", err(1'b1), 16'd1);
        check("oor_busy", bsy(1'b1), 16'd1);
        check("oor_novalid", vld(1'b1), 16'd0);
        tick();
        check("oor_err_off", err(1'b1), 16'd0);
        check("oor_free", bsy(1'b1), 16'd0);
        check("oor_novalid2", vld(1'b1), 16'd0);
        tick();
        check("oor_novalid3", vld(1'b1), 16'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
        tick();
        check("rst_o_a", o_of(1'b0), idle_o(1'b0));
        tick();
        for (int b = 0; b < 2; b++) begin
            check("rst_busy", bsy(b[0]), 16'd0);
            check("rst_valid", vld(b[0]), 16'd0);
            check("rst_err", err(b[0]), 16'd0);
            check("rst_o", o_of(b[0]), idle_o(b[0]));
        end
        rst = 1'b0;
        tick();

        for (int k = 0; k < 8; k++) wr(1'b0, 3'(k), 16'h00FF);
        clear_all(1'b0, 8);
        for (int k = 0; k < 8; k++) rd(1'b0, 3'(k), 1'b0);

        wr(1'b0, 3'd3, 16'h00A5);
        rd(1'b0, 3'd3, 1'b1);
        rd(1'b0, 3'd5, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [2:0] a;
            a = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) wr(1'b0, a, {8'h00, 8'($urandom)});
            else                           rd(1'b0, a, 1'($urandom_range(0, 1)));
        end

        // Reset lands on the 4th clear cycle: words 0..2 already zeroed.
        for (int k = 0; k < 8; k++) wr(1'b0, 3'(k), 16'h00FF);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_busy", bsy(1'b0), 16'd0);
        check("mid_valid", vld(1'b0), 16'd0);
        check("mid_err", err(1'b0), 16'd0);
        check("mid_o", o_of(1'b0), idle_o(1'b0));
        for (int k = 0; k < 8; k++) mdl_a[k] = (k < 3) ? 8'h00 : 8'hFF;
        for (int k = 0; k < 8; k++) rd(1'b0, 3'(k), 1'b0);

        clear_all(1'b1, 6);
        check("b_idle_zero", o_b, 16'h0000);
        wr(1'b1, 3'd4, 16'hBEEF);
        rd(1'b1, 3'd4, 1'b0);
        oor(1'b0, 3'd7, 16'h0);
        oor(1'b1, 3'd6, 16'h1234);
        for (int k = 0; k < 6; k++) rd(1'b1, 3'(k), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
